serial_addsub_mux: RTL

//  Multi-cycle add/subtract unit built from chained mux-based full-adder cells.

---
 rtl/serial_addsub_mux.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/serial_addsub_mux.sv
// ---------------------------------------------------------------------------
// serial_addsub_mux
//   Multi-cycle add/subtract unit. Operands are consumed DIGIT bits per clock,
//   LSB first, through a chain of DIGIT mux-based full-adder cells. The full
//   WIDTH-bit result appears after L = WIDTH/DIGIT RUN cycles.
//   Subtraction is a - b - cin, formed as a + ~b + ~cin.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   DIGIT   bits processed per cycle (must divide WIDTH)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   start   request, sampled only in IDLE or DONE
//   mode    0 = add, 1 = subtract
//   a, b    operands, captured on accept
//   cin     carry-in (add) / borrow-in (sub), captured on accept
//   busy    high while in RUN
//   done    one-cycle pulse when result/cout/ovf become valid
//   result  sum/difference, held until the next completed operation
//   cout    carry-out (add) / borrow-out (sub)
//   ovf     two's-complement signed overflow
//
// Configuration
//   SERIAL_ADDSUB_SATURATE_EN  when defined, an overflowing result is clamped
//   to the most positive/negative value according to the sign of A; cout and
//   ovf still report the unclamped arithmetic.
// ---------------------------------------------------------------------------
module serial_addsub_mux #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int L  = WIDTH / DIGIT;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
`ifdef SERIAL_ADDSUB_SATURATE_EN
  logic             r_a_sign;
`endif

  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_result;
  logic             w_carry_out;
  logic             w_carry_msb;
  logic             w_cout;
  logic             w_ovf;
  logic             w_last;

  // Chain of DIGIT mux cells. Each cell uses {a,b} as the select of two 4:1
  // muxes: sum picks from {c,~c,~c,c}, carry from {0,c,c,1}.
  always_comb begin
    logic       v_c;
    logic [1:0] v_sel;
    logic [3:0] v_sum_tbl;
    logic [3:0] v_cry_tbl;
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_sum_next  = r_sum >> DIGIT;
    w_carry_msb = 1'b0;
    v_c         = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      // Carry entering the top cell; on the final digit this is the carry
      // into the operand MSB, needed for signed overflow.
      if (i == DIGIT - 1) w_carry_msb = v_c;
      v_sel     = {r_a[i], r_b[i]};
      v_sum_tbl = {v_c, ~v_c, ~v_c, v_c};
      v_cry_tbl = {1'b1, v_c, v_c, 1'b0};
      w_sum_next[WIDTH-DIGIT+i] = v_sum_tbl[v_sel];
      v_c       = v_cry_tbl[v_sel];
    end
    w_carry_out = v_c;
  end

  assign w_last = (r_cnt == CW'(L - 1));
  assign w_cout = r_mode ? ~w_carry_out : w_carry_out;
  assign w_ovf  = w_carry_msb ^ w_carry_out;

`ifdef SERIAL_ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_result = w_ovf ? (r_a_sign ? MIN_NEG : MAX_POS) : w_sum_next;
`else
  assign w_result = w_sum_next;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_ADDSUB_SATURATE_EN
      r_a_sign <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sum_next;
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= w_result;
            cout    <= w_cout;
            ovf     <= w_ovf;
          end
        end
        default: begin  // S_IDLE and S_DONE accept a new request
          done <= 1'b0;
          if (start) begin
            r_state  <= S_RUN;
            r_a      <= a;
            r_b      <= mode ? ~b : b;
            r_mode   <= mode;
            r_carry  <= mode ? ~cin : cin;
            r_cnt    <= '0;
`ifdef SERIAL_ADDSUB_SATURATE_EN
            r_a_sign <= a[WIDTH-1];
`endif
            busy     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
